// File: rtl/microwave_pkg.sv
// Shared state encoding and keypad codes for the microwave time-entry controller.
package microwave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_START = 4'hA;
  localparam logic [3:0] KEY_STOP  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  function automatic logic isDigitKey(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second decrement of a BCD MM:SS value, with zero detect
// on the decremented result.
module bcd_mmss_dec (
  input  logic [3:0] i_d1,
  input  logic [3:0] i_d2,
  input  logic [3:0] i_d3,
  input  logic [3:0] i_d4,
  output logic [3:0] o_d1,
  output logic [3:0] o_d2,
  output logic [3:0] o_d3,
  output logic [3:0] o_d4,
  output logic       o_is_zero
);

  // Seconds wrap to 59 and borrow one minute when both seconds digits are 0
  always_comb begin
    o_d1 = i_d1;
    o_d2 = i_d2;
    o_d3 = i_d3;
    o_d4 = i_d4;
    if (i_d1 != 4'd0) begin
      o_d1 = i_d1 - 4'd1;
    end else if (i_d2 != 4'd0) begin
      o_d1 = 4'd9;
      o_d2 = i_d2 - 4'd1;
    end else begin
      o_d1 = 4'd9;
      o_d2 = 4'd5;
      if (i_d3 != 4'd0) begin
        o_d3 = i_d3 - 4'd1;
      end else begin
        o_d3 = 4'd9;
        o_d4 = i_d4 - 4'd1;
      end
    end
    o_is_zero = (o_d1 == 4'd0) && (o_d2 == 4'd0) && (o_d3 == 4'd0) && (o_d4 == 4'd0);
  end

endmodule

// File: rtl/time_entry_ctrl.sv
// Microwave keypad time entry and MM:SS countdown controller. All outputs are
// registered so nothing reaches the display bus or magnetron combinationally.
module time_entry_ctrl
  import microwave_pkg::*;
#(
  parameter int DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       tick_1hz,
  input  logic       door_open,
  output logic [3:0] display1,
  output logic [3:0] display2,
  output logic [3:0] display3,
  output logic [3:0] display4,
  output logic       running,
  output logic       beep,
  output logic       err
);

  localparam int CNT_W = (DONE_TICKS < 2) ? 1 : $clog2(DONE_TICKS);

  state_t           r_state, w_nextState;
  logic [3:0]       r_d1, r_d2, r_d3, r_d4;
  logic [3:0]       w_nd1, w_nd2, w_nd3, w_nd4;
  logic [3:0]       w_dec1, w_dec2, w_dec3, w_dec4;
  logic             w_decZero;
  logic [CNT_W-1:0] r_doneCnt, w_nextCnt;
  logic             r_running, r_beep, r_err, w_nextErr;
  logic             w_digit, w_start, w_stop, w_clear, w_anyKey, w_timeSet;

  bcd_mmss_dec u_dec (
    .i_d1     (r_d1),
    .i_d2     (r_d2),
    .i_d3     (r_d3),
    .i_d4     (r_d4),
    .o_d1     (w_dec1),
    .o_d2     (w_dec2),
    .o_d3     (w_dec3),
    .o_d4     (w_dec4),
    .o_is_zero(w_decZero)
  );

  assign w_digit   = key_valid && isDigitKey(key_code);
  assign w_start   = key_valid && (key_code == KEY_START);
  assign w_stop    = key_valid && (key_code == KEY_STOP);
  assign w_clear   = key_valid && (key_code == KEY_CLEAR);
  assign w_anyKey  = key_valid && (key_code <= KEY_CLEAR);
  assign w_timeSet = (r_d2 <= 4'd5) && ({r_d4, r_d3, r_d2, r_d1} != 16'h0000);

  always_comb begin
    w_nextState = r_state;
    w_nd1       = r_d1;
    w_nd2       = r_d2;
    w_nd3       = r_d3;
    w_nd4       = r_d4;
    w_nextCnt   = r_doneCnt;
    w_nextErr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_digit) begin
          w_nd4 = r_d3;
          w_nd3 = r_d2;
          w_nd2 = r_d1;
          w_nd1 = key_code;
        end else if (w_clear) begin
          {w_nd4, w_nd3, w_nd2, w_nd1} = 16'h0000;
        end else if (w_start) begin
          if (!door_open && w_timeSet) w_nextState = ST_RUN;
          else                         w_nextErr   = 1'b1;
        end
      end
      // Stop and door take priority over a coincident tick, which is dropped
      ST_RUN: begin
        if (w_stop || door_open) begin
          w_nextState = ST_PAUSE;
        end else if (tick_1hz) begin
          {w_nd4, w_nd3, w_nd2, w_nd1} = {w_dec4, w_dec3, w_dec2, w_dec1};
          if (w_decZero) begin
            w_nextState = ST_DONE;
            w_nextCnt   = '0;
          end
        end
      end
      ST_PAUSE: begin
        if (w_start) begin
          if (!door_open) w_nextState = ST_RUN;
          else            w_nextErr   = 1'b1;
        end else if (w_stop || w_clear) begin
          {w_nd4, w_nd3, w_nd2, w_nd1} = 16'h0000;
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        {w_nd4, w_nd3, w_nd2, w_nd1} = 16'h0000;
        if (w_anyKey) begin
          w_nextState = ST_IDLE;
          w_nextCnt   = '0;
        end else if (tick_1hz) begin
          if (r_doneCnt == CNT_W'(DONE_TICKS - 1)) begin
            w_nextState = ST_IDLE;
            w_nextCnt   = '0;
          end else begin
            w_nextCnt = r_doneCnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // Status flags are registered from the next state so they track it exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_d1      <= 4'd0;
      r_d2      <= 4'd0;
      r_d3      <= 4'd0;
      r_d4      <= 4'd0;
      r_doneCnt <= '0;
      r_running <= 1'b0;
      r_beep    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_d1      <= w_nd1;
      r_d2      <= w_nd2;
      r_d3      <= w_nd3;
      r_d4      <= w_nd4;
      r_doneCnt <= w_nextCnt;
      r_running <= (w_nextState == ST_RUN);
      r_beep    <= (w_nextState == ST_DONE);
      r_err     <= w_nextErr;
    end
  end

  assign display1 = r_d1;
  assign display2 = r_d2;
  assign display3 = r_d3;
  assign display4 = r_d4;
  assign running  = r_running;
  assign beep     = r_beep;
  assign err      = r_err;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed scoreboard bench for time_entry_ctrl: expected outputs are queued
// with each step and popped against the registered outputs.
module tb_time_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       tick_1hz = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] display1, display2, display3, display4;
  logic       running, beep, err;

  typedef struct {
    string       tag;
    logic [18:0] val;
  } exp_t;

  exp_t sbQ[$];
  int   checks   = 0;
  int   failures = 0;

  time_entry_ctrl #(.DONE_TICKS(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .tick_1hz (tick_1hz),
    .door_open(door_open),
    .display1 (display1),
    .display2 (display2),
    .display3 (display3),
    .display4 (display4),
    .running  (running),
    .beep     (beep),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Independent reference: whole seconds to {MM tens, MM units, SS tens, SS units}
  function automatic logic [15:0] toBcd(input int secs);
    return {4'(secs / 600), 4'((secs / 60) % 10), 4'((secs % 60) / 10), 4'(secs % 10)};
  endfunction

  // One clock of stimulus, launched and retired on falling edges
  task automatic applyStimulus(input bit doKey, input logic [3:0] code, input bit doTick);
    @(negedge clk);
    key_valid = doKey;
    key_code  = code;
    tick_1hz  = doTick;
    @(negedge clk);
    key_valid = 1'b0;
    tick_1hz  = 1'b0;
  endtask

  task automatic expectOut(input string tag, input logic [15:0] dig,
                           input logic run, input logic bp, input logic er);
    exp_t e;
    e.tag = tag;
    e.val = {dig, run, bp, er};
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [18:0] obs;
    checks++;
    if (sbQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: observed=empty required=entry");
      return;
    end
    e   = sbQ.pop_front();
    obs = {display4, display3, display2, display1, running, beep, err};
    assert (obs === e.val)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed digits=%h run=%b beep=%b err=%b required digits=%h run=%b beep=%b err=%b",
             e.tag, obs[18:3], obs[2], obs[1], obs[0], e.val[18:3], e.val[2], e.val[1], e.val[0]);
    end
  endtask

  task automatic step(input string tag, input bit doKey, input logic [3:0] code, input bit doTick,
                      input logic [15:0] dig, input logic run, input logic bp, input logic er);
    applyStimulus(doKey, code, doTick);
    expectOut(tag, dig, run, bp, er);
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #1;
    expectOut("reset_state", 16'h0000, 0, 0, 0);
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Entry and shift-out of the oldest digit
    step("key1", 1, 4'd1, 0, 16'h0001, 0, 0, 0);
    step("key2", 1, 4'd2, 0, 16'h0012, 0, 0, 0);
    step("key3", 1, 4'd3, 0, 16'h0123, 0, 0, 0);
    step("key4", 1, 4'd4, 0, 16'h1234, 0, 0, 0);
    step("key5", 1, 4'd5, 0, 16'h2345, 0, 0, 0);
    step("clear", 1, 4'hC, 0, 16'h0000, 0, 0, 0);
    step("key1b", 1, 4'd1, 0, 16'h0001, 0, 0, 0);
    step("reserved_key", 1, 4'hE, 0, 16'h0001, 0, 0, 0);
    step("idle_tick", 0, 4'd0, 1, 16'h0001, 0, 0, 0);
    step("clear2", 1, 4'hC, 0, 16'h0000, 0, 0, 0);

    // Countdown from 01:00 through DONE
    step("e100_1", 1, 4'd1, 0, 16'h0001, 0, 0, 0);
    step("e100_0", 1, 4'd0, 0, 16'h0010, 0, 0, 0);
    step("e100_00", 1, 4'd0, 0, 16'h0100, 0, 0, 0);
    step("start_run", 1, 4'hA, 0, 16'h0100, 1, 0, 0);
    step("run_digit_ignored", 1, 4'd7, 0, 16'h0100, 1, 0, 0);
    step("tick_0059", 0, 4'd0, 1, toBcd(59), 1, 0, 0);
    for (int t = 2; t <= 60; t++) begin
      step($sformatf("count_t%0d", t), 0, 4'd0, 1, toBcd(60 - t),
           (60 - t) != 0, (60 - t) == 0, 0);
    end
    step("done_idle_cycle", 0, 4'd0, 0, 16'h0000, 0, 1, 0);
    step("done_tick1", 0, 4'd0, 1, 16'h0000, 0, 1, 0);
    step("done_tick2", 0, 4'd0, 1, 16'h0000, 0, 1, 0);
    step("done_tick3_idle", 0, 4'd0, 1, 16'h0000, 0, 0, 0);

    // Rejected START cases
    step("e070_0", 1, 4'd0, 0, 16'h0000, 0, 0, 0);
    step("e070_7", 1, 4'd7, 0, 16'h0007, 0, 0, 0);
    step("e070_00", 1, 4'd0, 0, 16'h0070, 0, 0, 0);
    step("reject_tens7", 1, 4'hA, 0, 16'h0070, 0, 0, 1);
    step("err_drops", 0, 4'd0, 0, 16'h0070, 0, 0, 0);
    step("still_idle", 1, 4'd1, 0, 16'h0701, 0, 0, 0);
    step("clear3", 1, 4'hC, 0, 16'h0000, 0, 0, 0);
    step("reject_zero", 1, 4'hA, 0, 16'h0000, 0, 0, 1);
    step("e15_1", 1, 4'd1, 0, 16'h0001, 0, 0, 0);
    step("e15_5", 1, 4'd5, 0, 16'h0015, 0, 0, 0);
    door_open = 1'b1;
    step("reject_door", 1, 4'hA, 0, 16'h0015, 0, 0, 1);
    door_open = 1'b0;
    step("err_drops2", 0, 4'd0, 0, 16'h0015, 0, 0, 0);

    // Pause on door with a coincident tick, resume, stop twice
    step("clear4", 1, 4'hC, 0, 16'h0000, 0, 0, 0);
    step("e31_3", 1, 4'd3, 0, 16'h0003, 0, 0, 0);
    step("e31_1", 1, 4'd1, 0, 16'h0031, 0, 0, 0);
    step("start31", 1, 4'hA, 0, 16'h0031, 1, 0, 0);
    step("tick_0030", 0, 4'd0, 1, 16'h0030, 1, 0, 0);
    door_open = 1'b1;
    step("door_tick_pause", 0, 4'd0, 1, 16'h0030, 0, 0, 0);
    step("pause_start_door", 1, 4'hA, 0, 16'h0030, 0, 0, 1);
    door_open = 1'b0;
    step("pause_digit_ignored", 1, 4'd9, 0, 16'h0030, 0, 0, 0);
    step("pause_resume", 1, 4'hA, 0, 16'h0030, 1, 0, 0);
    step("stop_pause", 1, 4'hB, 0, 16'h0030, 0, 0, 0);
    step("stop_idle", 1, 4'hB, 0, 16'h0000, 0, 0, 0);

    // Minutes borrow 10:00 -> 09:59
    step("e1000_1", 1, 4'd1, 0, 16'h0001, 0, 0, 0);
    step("e1000_2", 1, 4'd0, 0, 16'h0010, 0, 0, 0);
    step("e1000_3", 1, 4'd0, 0, 16'h0100, 0, 0, 0);
    step("e1000_4", 1, 4'd0, 0, 16'h1000, 0, 0, 0);
    step("start1000", 1, 4'hA, 0, 16'h1000, 1, 0, 0);
    step("borrow_0959", 0, 4'd0, 1, 16'h0959, 1, 0, 0);
    step("stop_b1", 1, 4'hB, 0, 16'h0959, 0, 0, 0);
    step("stop_b2", 1, 4'hB, 0, 16'h0000, 0, 0, 0);

    // Any key leaves DONE at once
    step("e2", 1, 4'd2, 0, 16'h0002, 0, 0, 0);
    step("start2", 1, 4'hA, 0, 16'h0002, 1, 0, 0);
    step("tick_0001", 0, 4'd0, 1, 16'h0001, 1, 0, 0);
    step("tick_done", 0, 4'd0, 1, 16'h0000, 0, 1, 0);
    step("done_key_exit", 1, 4'd5, 0, 16'h0000, 0, 0, 0);

    // Asynchronous reset mid-RUN at 05:12
    step("e512_5", 1, 4'd5, 0, 16'h0005, 0, 0, 0);
    step("e512_1", 1, 4'd1, 0, 16'h0051, 0, 0, 0);
    step("e512_2", 1, 4'd2, 0, 16'h0512, 0, 0, 0);
    step("start512", 1, 4'hA, 0, 16'h0512, 1, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    expectOut("async_reset", 16'h0000, 0, 0, 0);
    checkOutput();
    step("key_in_reset", 1, 4'd3, 0, 16'h0000, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step("resume_key", 1, 4'd4, 0, 16'h0004, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
